// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one fixed-latency memory between the fetch (IF)
// and data (MEM) stages. Data has priority, and a fetch starvation limit bounds that priority.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic          clk_i,
   input  logic          resetn_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [DW-1:0] if_rdata_o,
   output logic          if_ready_o,
   input  logic          dm_req_i,
   input  logic          dm_we_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic [DW-1:0] dm_rdata_o,
   output logic          dm_ready_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          stall_if_o,
   output logic          stall_mem_o,
   output logic          busy_o
);

   localparam int unsigned SW = $clog2(STARVE_LIM + 1);
   localparam int unsigned LW = $clog2(MEM_LAT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
   localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT);
   localparam logic [LW-1:0] LAT_ONE    = LW'(1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic          gnt_if_q, gnt_if_d;
   logic          grant_if;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q  <= IDLE;
         starve_q <= '0;
         lat_q    <= '0;
         rdata_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         gnt_if_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         lat_q    <= lat_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         gnt_if_q <= gnt_if_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      lat_d    = lat_q;
      rdata_d  = rdata_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      gnt_if_d = gnt_if_q;
      // MEM holds the older instruction, so fetch only wins when data is idle or starved out.
      grant_if = if_req_i && (!dm_req_i || (starve_q == STARVE_MAX));

      case (state_q)
         IDLE: begin
            if (if_req_i || dm_req_i) begin
               state_d  = ACCESS;
               gnt_if_d = grant_if;
               if (grant_if) begin
                  addr_d   = if_addr_i;
                  we_d     = 1'b0;
                  starve_d = '0;
               end else begin
                  addr_d  = dm_addr_i;
                  we_d    = dm_we_i;
                  wdata_d = dm_wdata_i;
                  if (!if_req_i) begin
                     starve_d = '0;
                  end else if (starve_q != STARVE_MAX) begin
                     starve_d = starve_q + SW'(1);
                  end
               end
            end
         end
         ACCESS: begin
            state_d = WAIT;
            lat_d   = LAT_INIT;
         end
         WAIT: begin
            lat_d = lat_q - LW'(1);
            if (lat_q == LAT_ONE) begin
               if (!we_q) begin
                  rdata_d = mem_rdata_i;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_en_o    = (state_q == ACCESS);
   assign mem_we_o    = (state_q == ACCESS) && we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign if_ready_o  = (state_q == RESP) && gnt_if_q;
   assign dm_ready_o  = (state_q == RESP) && !gnt_if_q;
   assign if_rdata_o  = rdata_q;
   assign dm_rdata_o  = rdata_q;
   assign stall_if_o  = if_req_i && !if_ready_o;
   assign stall_mem_o = dm_req_i && !dm_ready_o;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default build plus a MEM_LAT=1 build, each with
// a small memory model that presents read data only in the cycle the latency allows.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem, busy;

   logic        if_req1, dm_req1, dm_we1;
   logic [31:0] if_addr1, dm_addr1, dm_wdata1;
   logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_ready1, dm_ready1, mem_en1, mem_we1, stall_if1, stall_mem1, busy1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_LIM(4)) u_dut (
      .clk_i(clk), .resetn_i(resetn),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .stall_if_o(stall_if), .stall_mem_o(stall_mem), .busy_o(busy)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIM(4)) u_dut1 (
      .clk_i(clk), .resetn_i(resetn),
      .if_req_i(if_req1), .if_addr_i(if_addr1), .if_rdata_o(if_rdata1), .if_ready_o(if_ready1),
      .dm_req_i(dm_req1), .dm_we_i(dm_we1), .dm_addr_i(dm_addr1), .dm_wdata_i(dm_wdata1),
      .dm_rdata_o(dm_rdata1), .dm_ready_o(dm_ready1),
      .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
      .mem_rdata_i(mem_rdata1), .stall_if_o(stall_if1), .stall_mem_o(stall_mem1), .busy_o(busy1)
   );

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h10) return 32'h8C01_0004;
      return 32'hC0DE_0000 | a;
   endfunction

   // Memory models: read data is valid only MEM_LAT cycles after the mem_en cycle.
   bit [31:0]   mem0 [0:63];
   bit          wv0  [0:63];
   bit          pend0, pend1;
   int unsigned cnt0, cnt1;
   logic [31:0] ra0, ra1;

   always @(posedge clk) begin
      if (mem_en && !mem_we) begin
         pend0 <= 1'b1;
         cnt0  <= 1;
         ra0   <= mem_addr;
      end else if (pend0) begin
         cnt0 <= cnt0 + 1;
      end
      if (mem_en && mem_we) begin
         mem0[mem_addr[7:2]] <= mem_wdata;
         wv0[mem_addr[7:2]]  <= 1'b1;
      end
      if (mem_en1 && !mem_we1) begin
         pend1 <= 1'b1;
         cnt1  <= 1;
         ra1   <= mem_addr1;
      end else if (pend1) begin
         cnt1 <= cnt1 + 1;
      end
   end

   assign mem_rdata  = (pend0 && cnt0 == 2) ?
                       (wv0[ra0[7:2]] ? mem0[ra0[7:2]] : init_word(ra0)) : 32'hBAD0_BAD0;
   assign mem_rdata1 = (pend1 && cnt1 == 1) ? init_word(ra1) : 32'hBAD1_BAD1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      if_req = 1'b1; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      if_req1 = 1'b0; if_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
      tick();
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
      n_vec++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL reset_if_ready: got %b expected 0", if_ready); end
      n_vec++; if (dm_ready !== 1'b0) begin n_err++; $display("FAIL reset_dm_ready: got %b expected 0", dm_ready); end
      n_vec++; if (if_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", if_rdata); end
      n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
      n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
      n_vec++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL reset_stall_if: got %b expected 1", stall_if); end
      n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
      if_req = 1'b0;
      #1;
      n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL reset_stall_if_low: got %b expected 0", stall_if); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_fetch_only;
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_c0_busy: got %b expected 0", busy); end
      n_vec++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_c0_stall: got %b expected 1", stall_if); end
      for (int c = 1; c <= 4; c++) begin
         tick();
         n_vec++; if (mem_en !== (c == 1)) begin n_err++; $display("FAIL fetch_mem_en c%0d: got %b expected %b", c, mem_en, c == 1); end
         n_vec++; if (if_ready !== (c == 4)) begin n_err++; $display("FAIL fetch_if_ready c%0d: got %b expected %b", c, if_ready, c == 4); end
         n_vec++; if (dm_ready !== 1'b0) begin n_err++; $display("FAIL fetch_dm_ready c%0d: got %b expected 0", c, dm_ready); end
         if (c == 1) begin
            n_vec++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL fetch_mem_addr: got %h expected 00000010", mem_addr); end
            n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_mem_we: got %b expected 0", mem_we); end
         end
         if (c == 4) begin
            n_vec++; if (if_rdata !== 32'h8C01_0004) begin n_err++; $display("FAIL fetch_rdata: got %h expected 8c010004", if_rdata); end
            n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL fetch_stall_c4: got %b expected 0", stall_if); end
         end
      end
      if_req = 1'b0;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_c5_busy: got %b expected 0", busy); end
   endtask

   task automatic test_simultaneous;
      if_req = 1'b1; if_addr = 32'h14;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h04;
      for (int c = 1; c <= 9; c++) begin
         tick();
         n_vec++; if (dm_ready !== (c == 4)) begin n_err++; $display("FAIL simul_dm_ready c%0d: got %b expected %b", c, dm_ready, c == 4); end
         n_vec++; if (if_ready !== (c == 9)) begin n_err++; $display("FAIL simul_if_ready c%0d: got %b expected %b", c, if_ready, c == 9); end
         n_vec++; if (mem_en !== (c == 1 || c == 6)) begin n_err++; $display("FAIL simul_mem_en c%0d: got %b expected %b", c, mem_en, c == 1 || c == 6); end
         if (c == 1) begin
            n_vec++; if (mem_addr !== 32'h04) begin n_err++; $display("FAIL simul_addr_data: got %h expected 00000004", mem_addr); end
         end
         if (c == 2) begin
            n_vec++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL simul_stall_mem: got %b expected 1", stall_mem); end
         end
         if (c == 4) begin
            n_vec++; if (dm_rdata !== 32'hC0DE_0004) begin n_err++; $display("FAIL simul_dm_rdata: got %h expected c0de0004", dm_rdata); end
            dm_req = 1'b0;
         end
         if (c == 6) begin
            n_vec++; if (mem_addr !== 32'h14) begin n_err++; $display("FAIL simul_addr_fetch: got %h expected 00000014", mem_addr); end
         end
         if (c == 9) begin
            n_vec++; if (if_rdata !== 32'hC0DE_0014) begin n_err++; $display("FAIL simul_if_rdata: got %h expected c0de0014", if_rdata); end
            if_req = 1'b0;
         end
      end
      tick();
   endtask

   task automatic test_store;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h08; dm_wdata = 32'hDEAD_BEEF;
      for (int c = 1; c <= 4; c++) begin
         tick();
         n_vec++; if (mem_en !== (c == 1)) begin n_err++; $display("FAIL store_mem_en c%0d: got %b expected %b", c, mem_en, c == 1); end
         n_vec++; if (mem_we !== (c == 1)) begin n_err++; $display("FAIL store_mem_we c%0d: got %b expected %b", c, mem_we, c == 1); end
         n_vec++; if (dm_ready !== (c == 4)) begin n_err++; $display("FAIL store_dm_ready c%0d: got %b expected %b", c, dm_ready, c == 4); end
         if (c == 1) begin
            n_vec++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_wdata: got %h expected deadbeef", mem_wdata); end
         end
         if (c == 1 || c == 3) begin
            n_vec++; if (mem_addr !== 32'h08) begin n_err++; $display("FAIL store_addr c%0d: got %h expected 00000008", c, mem_addr); end
         end
         if (c == 4) begin
            n_vec++; if (dm_rdata !== 32'hC0DE_0014) begin n_err++; $display("FAIL store_rdata_kept: got %h expected c0de0014", dm_rdata); end
         end
      end
      dm_req = 1'b0; dm_we = 1'b0;
      tick();
   endtask

   task automatic test_starvation;
      if_req = 1'b1; if_addr = 32'h18;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
      for (int c = 1; c <= 49; c++) begin
         logic rdy, is_if;
         tick();
         rdy   = (c % 5 == 4);
         is_if = (c == 24 || c == 49);
         n_vec++; if (if_ready !== (rdy && is_if)) begin n_err++; $display("FAIL starve_if_ready c%0d: got %b expected %b", c, if_ready, rdy && is_if); end
         n_vec++; if (dm_ready !== (rdy && !is_if)) begin n_err++; $display("FAIL starve_dm_ready c%0d: got %b expected %b", c, dm_ready, rdy && !is_if); end
         if (rdy && is_if) begin
            n_vec++; if (if_rdata !== 32'hC0DE_0018) begin n_err++; $display("FAIL starve_if_rdata c%0d: got %h expected c0de0018", c, if_rdata); end
         end
         if (rdy && !is_if) begin
            n_vec++; if (dm_rdata !== 32'hC0DE_0020) begin n_err++; $display("FAIL starve_dm_rdata c%0d: got %h expected c0de0020", c, dm_rdata); end
         end
      end
      if_req = 1'b0; dm_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_wait;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h08;
      tick();
      n_vec++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL rstw_mem_en_c1: got %b expected 1", mem_en); end
      tick();
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstw_busy_c2: got %b expected 1", busy); end
      resetn = 1'b0;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstw_busy: got %b expected 0", busy); end
      n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rstw_mem_en: got %b expected 0", mem_en); end
      n_vec++; if (dm_ready !== 1'b0) begin n_err++; $display("FAIL rstw_dm_ready: got %b expected 0", dm_ready); end
      n_vec++; if (dm_rdata !== 32'h0) begin n_err++; $display("FAIL rstw_rdata: got %h expected 0", dm_rdata); end
      n_vec++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL rstw_stall_mem: got %b expected 1", stall_mem); end
      resetn = 1'b1;
      for (int c = 4; c <= 7; c++) begin
         tick();
         n_vec++; if (dm_ready !== (c == 7)) begin n_err++; $display("FAIL rstw_reissue_ready c%0d: got %b expected %b", c, dm_ready, c == 7); end
         n_vec++; if (mem_en !== (c == 4)) begin n_err++; $display("FAIL rstw_reissue_mem_en c%0d: got %b expected %b", c, mem_en, c == 4); end
         if (c == 7) begin
            n_vec++; if (dm_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rstw_reissue_rdata: got %h expected deadbeef", dm_rdata); end
         end
      end
      dm_req = 1'b0;
      tick();
   endtask

   task automatic test_mem_lat1;
      dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h0C;
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_vec++; if (dm_ready1 !== (c == 3)) begin n_err++; $display("FAIL lat1_dm_ready c%0d: got %b expected %b", c, dm_ready1, c == 3); end
         n_vec++; if (mem_en1 !== (c == 1)) begin n_err++; $display("FAIL lat1_mem_en c%0d: got %b expected %b", c, mem_en1, c == 1); end
         n_vec++; if (if_ready1 !== 1'b0) begin n_err++; $display("FAIL lat1_if_ready c%0d: got %b expected 0", c, if_ready1); end
         if (c == 1) begin
            n_vec++; if (mem_we1 !== 1'b0) begin n_err++; $display("FAIL lat1_mem_we: got %b expected 0", mem_we1); end
            n_vec++; if (mem_wdata1 !== 32'h0) begin n_err++; $display("FAIL lat1_mem_wdata: got %h expected 0", mem_wdata1); end
            n_vec++; if (stall_mem1 !== 1'b1) begin n_err++; $display("FAIL lat1_stall_mem: got %b expected 1", stall_mem1); end
            n_vec++; if (stall_if1 !== 1'b0) begin n_err++; $display("FAIL lat1_stall_if: got %b expected 0", stall_if1); end
         end
         if (c == 3) begin
            n_vec++; if (dm_rdata1 !== 32'hC0DE_000C) begin n_err++; $display("FAIL lat1_dm_rdata: got %h expected c0de000c", dm_rdata1); end
            n_vec++; if (if_rdata1 !== 32'hC0DE_000C) begin n_err++; $display("FAIL lat1_if_rdata: got %h expected c0de000c", if_rdata1); end
         end
      end
      dm_req1 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_simultaneous();
      test_store();
      test_starvation();
      test_reset_mid_wait();
      test_mem_lat1();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the 5-stage pipeline. Shares one unified instruction/data memory between the IF stage (fetch requester) and the MEM stage (load/store requester). It sequences each access through a fixed-latency memory and returns one-cycle ready pulses. It also drives per-stage stall signals that the pipeline ORs into its existing stall logic.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, memory read latency in cycles after the mem_en cycle (legal range 1–8)
- STARVE_LIM, 4, consecutive data grants allowed while a fetch is pending (≥1)

Ports (one clock; reset is synchronous and active-low):
- Clock  in  1  rising-edge clock
- Resetn  in  1  synchronous active-low reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  AW  fetch address, stable while if_req
- if_rdata  out  DW  fetched word, valid only when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1=store, 0=load; stable while dm_req
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data, valid only when dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  dm_req & ~dm_ready (combinational)
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE:** if either request is high, pick a grant and latch the winner's addr, we and wdata into internal registers; go to ACCESS. If neither is high, stay.
- **Grant rule:**
  - Fetch wins only if if_req && (!dm_req || starve_cnt == STARVE_LIM).
  - Otherwise data wins.
  - Data priority exists because MEM holds the older instruction.
- **starve_cnt** (width clog2(STARVE_LIM+1)), updated at the grant edge:
  - Data grant while if_req=1: +1 (saturating at STARVE_LIM).
  - Data grant while if_req=0: cleared to 0.
  - Fetch grant: cleared to 0.
- **ACCESS** (one cycle): mem_en=1; mem_we, mem_addr and mem_wdata come from the latched request. Go to WAIT with lat_cnt = MEM_LAT.
- **WAIT:** lat_cnt decrements each cycle. On the cycle lat_cnt==1:
  - Capture mem_rdata into rdata_q, loads and fetches only; stores leave rdata_q unchanged.
  - Go to RESP.
- **RESP** (one cycle): pulse the ready output of the granted port. if_rdata and dm_rdata both drive rdata_q. Go to IDLE.
- Outside ACCESS: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold the latched values.
- Requesters drop or change their request the cycle after ready. The arbiter re-arbitrates only in IDLE, so the held request is never double-served.
- If a request is deasserted mid-transaction (protocol violation), the transaction still completes and ready still pulses.
- Reset, including mid-transaction:
  - State → IDLE; starve_cnt, lat_cnt and rdata_q → 0.
  - if_ready, dm_ready, mem_en, mem_we and busy → 0; the latched addr/wdata → 0.
  - Any in-flight access is abandoned; the requester must reissue.
  - The stall outputs follow their combinational definition.

## Timing
- Request seen in IDLE at cycle 0 → mem_en at cycle 1 → mem_rdata sampled at the end of cycle 1+MEM_LAT → ready at cycle 2+MEM_LAT. With the default, ready comes at cycle 4.
- Throughput: one transaction per MEM_LAT+3 cycles (IDLE, ACCESS, MEM_LAT × WAIT, RESP).
- Loads and stores have identical timing.
- ready is never asserted for both ports in the same cycle.
- If both requests are present with starve_cnt < STARVE_LIM, data is granted. Fetch is granted at the next IDLE in which starve_cnt == STARVE_LIM, or in which dm_req is low.

## Test plan
- **Fetch only:** if_req=1, if_addr=0x10, memory returns 0x8C010004 → mem_en at cycle 1 with mem_addr=0x10, if_ready=1 at cycle 4 with if_rdata=0x8C010004, dm_ready=0 throughout.
- **Simultaneous request:** if_req and dm_req both asserted, dm_we=0, dm_addr=0x04 → data is served first (dm_ready at cycle 4). Fetch is then granted in the following IDLE, with if_ready at cycle 9.
- **Store:** dm_req=1, dm_we=1, dm_addr=0x08, dm_wdata=0xDEADBEEF → one cycle with mem_en=mem_we=1 carrying those values; dm_ready at cycle 4; rdata_q unchanged.
- **Starvation:** if_req held high while dm_req is re-raised continuously → exactly 4 data grants, then a fetch grant, then starve_cnt=0.
- **Reset mid-WAIT:** Resetn=0 for one cycle during WAIT of a load → next cycle busy=0, mem_en=0, no ready pulse, rdata_q=0. The reissued load then completes normally.
- **MEM_LAT=1 build:** single load → dm_ready at cycle 3 with correct data.
